// File: rtl/serializer_pkg.sv
// ---------------------------------------------------------------------------
// serializer_pkg
//
// Shared definitions for the self-test link serial transmitter.
//   - tx_state_t   : transmitter FSM states
//   - PREAMBLE     : two-bit frame preamble, sent MSB first
//   - PREAMBLE_LEN : preamble length in bits
//   - DEF_DATA_W / DEF_GAP_CYCLES : default payload width and idle gap
//
// Optional feature macro: SERIALIZER_TX_PARITY_EN
//   When defined, the PAR state exists and each frame carries a trailing
//   even-parity bit.
// ---------------------------------------------------------------------------
package serializer_pkg;

   localparam int         DEF_DATA_W     = 32;
   localparam int         DEF_GAP_CYCLES = 2;
   localparam logic [1:0] PREAMBLE       = 2'b11;
   localparam int         PREAMBLE_LEN   = 2;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE1 = 3'd1,
      PRE2 = 3'd2,
      DATA = 3'd3,
`ifdef SERIALIZER_TX_PARITY_EN
      PAR  = 3'd4,
`endif
      GAP  = 3'd5
   } tx_state_t;

endpackage

// File: rtl/serializer_tx_piso_shift_reg.sv
// ---------------------------------------------------------------------------
// piso_shift_reg
//
// DATA_W-bit parallel-in / serial-out register, MSB first.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset (clears the register)
//   load   in   capture d (takes priority over shift)
//   shift  in   shift left by one, zero filled
//   d      in   parallel word [DATA_W-1:0]
//   msb    out  current MSB of the register
//   parity out  XOR of the word captured at load (only with
//               SERIALIZER_TX_PARITY_EN)
// ---------------------------------------------------------------------------
module piso_shift_reg
   import serializer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] d,
   output logic              msb
`ifdef SERIALIZER_TX_PARITY_EN
   ,
   output logic              parity
`endif
);

   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
      end else if (load) begin
         r_data <= d;
      end else if (shift) begin
         r_data <= {r_data[DATA_W-2:0], 1'b0};
      end
   end

   assign msb = r_data[DATA_W-1];

`ifdef SERIALIZER_TX_PARITY_EN
   // Parity is taken from the word at capture time, because by the time
   // the parity bit is due the register has been shifted empty.
   logic r_parity;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_parity <= 1'b0;
      end else if (load) begin
         r_parity <= ^d;
      end
   end

   assign parity = r_parity;
`endif

endmodule

// File: rtl/serializer_tx.sv
// ---------------------------------------------------------------------------
// serializer_tx
//
// Serial transmitter for the self-test link. Accepts one DATA_W-bit word
// over a valid/ready handshake and sends it as a frame on a single line:
// preamble "11", then the payload MSB first, then (optionally) an even
// parity bit, then GAP_CYCLES forced-low cycles.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   din        in   [DATA_W-1:0] word to send, sampled on handshake only
//   din_valid  in   source has a word
//   din_ready  out  high in IDLE; handshake = din_valid & din_ready
//   sdo        out  registered serial line
//   busy       out  frame or gap in progress
//   done       out  one-cycle pulse in the first gap cycle
//
// Optional feature macro: SERIALIZER_TX_PARITY_EN (adds the PAR state).
// ---------------------------------------------------------------------------
module serializer_tx
   import serializer_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              sdo,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

   tx_state_t        r_state;
   tx_state_t        w_state_next;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [GAP_W-1:0] r_gap_cnt;
   logic             r_sdo;
   logic             r_done;

   logic             w_load;
   logic             w_shift;
   logic             w_msb;
   logic             w_sdo_next;
   logic             w_done_next;
`ifdef SERIALIZER_TX_PARITY_EN
   logic             w_parity;
`endif

   assign w_load = (r_state == IDLE) && din_valid;

   piso_shift_reg #(
      .DATA_W (DATA_W)
   ) u_piso (
      .clk    (clk),
      .rst    (rst),
      .load   (w_load),
      .shift  (w_shift),
      .d      (din),
      .msb    (w_msb)
`ifdef SERIALIZER_TX_PARITY_EN
      ,
      .parity (w_parity)
`endif
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (din_valid) begin
               w_state_next = PRE1;
            end
         end
         PRE1: w_state_next = PRE2;
         PRE2: w_state_next = DATA;
         DATA: begin
            if (r_bit_cnt == LAST_BIT) begin
`ifdef SERIALIZER_TX_PARITY_EN
               w_state_next = PAR;
`else
               w_state_next = GAP;
`endif
            end
         end
`ifdef SERIALIZER_TX_PARITY_EN
         PAR: w_state_next = GAP;
`endif
         GAP: begin
            if (r_gap_cnt == LAST_GAP) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Output logic. Decoded from the next state so that the line and the
   // done pulse come from flops aligned with the state they belong to.
   // Entering DATA presents the current MSB and shifts in the same edge,
   // so the register always holds the next bit to send at its MSB.
   always_comb begin
      w_sdo_next  = 1'b0;
      w_done_next = 1'b0;
      w_shift     = 1'b0;
      case (w_state_next)
         PRE1: w_sdo_next = PREAMBLE[PREAMBLE_LEN-1];
         PRE2: w_sdo_next = PREAMBLE[PREAMBLE_LEN-2];
         DATA: begin
            w_sdo_next = w_msb;
            w_shift    = 1'b1;
         end
`ifdef SERIALIZER_TX_PARITY_EN
         PAR: w_sdo_next = w_parity;
`endif
         GAP: w_done_next = (r_state != GAP);
         default: begin
            w_sdo_next  = 1'b0;
            w_done_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sdo  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_sdo  <= w_sdo_next;
         r_done <= w_done_next;
      end
   end

   // Bit counter: cleared on capture, advances once per DATA cycle and
   // returns to zero after the last payload bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt <= '0;
      end else if (w_load) begin
         r_bit_cnt <= '0;
      end else if (r_state == DATA) begin
         r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
      end
   end

   // Gap counter: counts GAP cycles, held at zero otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gap_cnt <= '0;
      end else if (r_state == GAP) begin
         r_gap_cnt <= (r_gap_cnt == LAST_GAP) ? '0 : r_gap_cnt + 1'b1;
      end else begin
         r_gap_cnt <= '0;
      end
   end

   assign din_ready = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign sdo       = r_sdo;
   assign done      = r_done;

endmodule

// File: tb/tb_serializer_tx.sv
module tb_serializer_tx;

   localparam int DATA_W = 32;
   localparam int GAP_C  = 2;
`ifdef SERIALIZER_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic              clk;
   logic              rst;
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic              sdo;
   logic              busy;
   logic              done;

   int n_chk;
   int n_fail;

   logic sdo_h  [0:127];
   logic done_h [0:127];
   logic rdy_h  [0:127];
   logic busy_h [0:127];

   serializer_tx #(
      .DATA_W     (DATA_W),
      .GAP_CYCLES (GAP_C)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .sdo       (sdo),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: a queue of the line/done values still owed for the
   // frame in flight. Empty queue means the transmitter is idle; a valid
   // word seen while idle schedules a whole frame from the link rules.
   // ------------------------------------------------------------------
   typedef struct packed {
      logic s;
      logic d;
   } slot_t;

   slot_t mq[$];

   always @(negedge clk) begin
      logic e_sdo, e_done, e_rdy, e_busy;
      slot_t sl;
      if (rst) begin
         mq.delete();
         e_sdo = 0; e_done = 0; e_rdy = 1; e_busy = 0;
      end else if (mq.size() > 0) begin
         sl = mq.pop_front();
         e_sdo = sl.s; e_done = sl.d; e_rdy = 0; e_busy = 1;
      end else begin
         e_sdo = 0; e_done = 0; e_rdy = 1; e_busy = 0;
         if (din_valid) begin
            mq.push_back('{s: 1'b1, d: 1'b0});
            mq.push_back('{s: 1'b1, d: 1'b0});
            for (int i = DATA_W - 1; i >= 0; i--)
               mq.push_back('{s: din[i], d: 1'b0});
            if (PB == 1)
               mq.push_back('{s: ^din, d: 1'b0});
            for (int g = 0; g < GAP_C; g++)
               mq.push_back('{s: 1'b0, d: (g == 0)});
         end
      end
      chk("model_sdo", {31'd0, sdo}, {31'd0, e_sdo});
      chk("model_done", {31'd0, done}, {31'd0, e_done});
      chk("model_ready", {31'd0, din_ready}, {31'd0, e_rdy});
      chk("model_busy", {31'd0, busy}, {31'd0, e_busy});
   end

   // ------------------------------------------------------------------
   // Directed stimulus, cycle k counted from the handshake cycle 0.
   // ------------------------------------------------------------------
   task automatic drive(input int t, input int k);
      case (t)
         1: begin
            if (k == 0) begin din = 32'hA5A5_0F0F; din_valid = 1; end
            else din_valid = 0;
         end
         2: begin
            if (k == 0) begin din = 32'hFFFF_FFFF; din_valid = 1; end
            else if (k == 1) din = 32'h0000_0001;
            else if (k == 38 + PB) din_valid = 0;
         end
         3: begin
            if (k == 0) begin din = 32'h1234_5678; din_valid = 1; end
            else if (k >= 5 && k <= 20) begin din = 32'hDEAD_BEEF; din_valid = k[0]; end
            else din_valid = 0;
         end
         4: begin
            if (k == 0) begin din = 32'hFFFF_0000; din_valid = 1; end
            else din_valid = 0;
            if (k == 12) rst = 1;
            if (k == 13) rst = 0;
         end
         5: begin
            if (k == 0) begin din = 32'h0000_0003; din_valid = 1; end
            else din_valid = 0;
         end
         default: begin
            if (k == 0) begin din = 32'h0000_0007; din_valid = 1; end
            else din_valid = 0;
         end
      endcase
   endtask

   task automatic run(input int t, input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         drive(t, k);
         if (t == 4 && k == 12) begin
            #1;
            chk("rst_async_sdo", {31'd0, sdo}, 32'd0);
         end
         @(negedge clk);
         sdo_h[k]  = sdo;
         done_h[k] = done;
         rdy_h[k]  = din_ready;
         busy_h[k] = busy;
      end
   endtask

   function automatic logic [31:0] payload();
      logic [31:0] p;
      p = '0;
      for (int i = 0; i < DATA_W; i++)
         p = {p[30:0], sdo_h[3 + i]};
      return p;
   endfunction

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst = 1;
      din = '0;
      din_valid = 0;

      // Reset held for 3 cycles, then idle outputs
      repeat (3) @(posedge clk);
      #1;
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_sdo", {31'd0, sdo}, 32'd0);
         chk("reset_ready", {31'd0, din_ready}, 32'd1);
         chk("reset_busy", {31'd0, busy}, 32'd0);
         chk("reset_done", {31'd0, done}, 32'd0);
      end

      // Single frame
      run(1, 40);
      chk("single_pre", {30'd0, sdo_h[1], sdo_h[2]}, 32'd3);
      chk("single_payload", payload(), 32'hA5A5_0F0F);
      chk("single_done_before", {31'd0, done_h[34 + PB]}, 32'd0);
      chk("single_done", {31'd0, done_h[35 + PB]}, 32'd1);
      chk("single_done_after", {31'd0, done_h[36 + PB]}, 32'd0);
      chk("single_ready_early", {31'd0, rdy_h[36 + PB]}, 32'd0);
      chk("single_ready", {31'd0, rdy_h[37 + PB]}, 32'd1);

      // Back-to-back with valid held high
      run(2, 90);
      chk("b2b_payload1", payload(), 32'hFFFF_FFFF);
      chk("b2b_gap", {29'd0, sdo_h[35 + PB], sdo_h[36 + PB], sdo_h[37 + PB]}, 32'd0);
      chk("b2b_pre2", {30'd0, sdo_h[38 + PB], sdo_h[39 + PB]}, 32'd3);
      chk("b2b_data2_lsb", {31'd0, sdo_h[38 + PB + 2 + 31]}, 32'd1);

      // din/din_valid activity while busy is ignored
      run(3, 50);
      chk("ignore_payload", payload(), 32'h1234_5678);
      for (int k = 37 + PB; k < 50; k++)
         chk("ignore_no_extra", {30'd0, sdo_h[k], busy_h[k]}, 32'd0);

      // Reset mid-frame
      run(4, 20);
      chk("midrst_busy", {31'd0, busy_h[13]}, 32'd0);
      chk("midrst_ready", {31'd0, rdy_h[13]}, 32'd1);
      for (int k = 12; k < 20; k++)
         chk("midrst_no_done", {31'd0, done_h[k]}, 32'd0);
      run(5, 45);
      chk("after_rst_payload", payload(), 32'h0000_0003);
`ifdef SERIALIZER_TX_PARITY_EN
      chk("parity_3", {31'd0, sdo_h[35]}, 32'd0);
      run(6, 45);
      chk("parity_7_payload", payload(), 32'h0000_0007);
      chk("parity_7", {31'd0, sdo_h[35]}, 32'd1);
      chk("parity_7_done", {31'd0, done_h[36]}, 32'd1);
`endif

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
